// File: rtl/uart_pkg.sv
// Shared definitions for the UART boot loader: FSM encoding, instruction width and ack byte.
package uart_pkg;

  localparam int INSTR_W = 32;
  localparam logic [7:0] ACK_BYTE_DEF = 8'hAA;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    ACK,
    RUN,
    ERR
  } state_t;

endpackage

// File: rtl/uart_word_assembler.sv
// Packs little-endian bytes into 32-bit words and flags each completed word one cycle later.
import uart_pkg::*;

module uart_word_assembler (
  input  logic               clk,
  input  logic               rstn,
  input  logic               byte_vld,
  input  logic [7:0]         byte_in,
  output logic               word_vld_p1,
  output logic [INSTR_W-1:0] word_p1
);

  logic [1:0]         byte_cnt;
  logic [INSTR_W-1:0] shift_p1;

  // Stage p1: shift in from the top so the first byte ends up in the low lane
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt    <= 2'd0;
      shift_p1    <= '0;
      word_vld_p1 <= 1'b0;
    end else begin
      word_vld_p1 <= 1'b0;
      if (byte_vld) begin
        shift_p1    <= {byte_in, shift_p1[INSTR_W-1:8]};
        byte_cnt    <= byte_cnt + 2'd1;
        word_vld_p1 <= (byte_cnt == 2'd3);
      end
    end
  end

  assign word_p1 = shift_p1;

endmodule

// File: rtl/uart_loader.sv
// Boot loader: receives a word count and program words over UART, writes them to instruction
// memory, sends an ack byte and then releases the core from reset.
import uart_pkg::*;

module uart_loader #(
  parameter int         ADDR_WIDTH = 10,
  parameter int         MAX_WORDS  = 1024,
  parameter logic [7:0] ACK_BYTE   = ACK_BYTE_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            rx_data,
  input  logic                  rx_ready,
  input  logic                  rx_ferr,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [INSTR_W-1:0]    imem_wdata,
  output logic                  core_rstn,
  output logic                  load_done,
  output logic                  load_err
);

  localparam logic [INSTR_W-1:0]  MAX_N   = INSTR_W'(MAX_WORDS);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH:0]   word_count;
  logic                  byte_vld;
  logic                  bad_byte;
  logic                  word_vld_p1;
  logic [INSTR_W-1:0]    word_p1;
  logic                  last_word;

  // Only HDR and DATA listen to the receiver; a framing error discards the byte
  assign bad_byte = rx_ready && rx_ferr && (state == HDR || state == DATA);
  assign byte_vld = rx_ready && !rx_ferr && (state == HDR || state == DATA);

  uart_word_assembler u_asm (
    .clk         (clk),
    .rstn        (rstn),
    .byte_vld    (byte_vld),
    .byte_in     (rx_data),
    .word_vld_p1 (word_vld_p1),
    .word_p1     (word_p1)
  );

  assign last_word = ({1'b0, word_idx} == (word_count - CNT_ONE));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= HDR;
      word_idx   <= '0;
      word_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == HDR && word_vld_p1) begin
        word_count <= word_p1[ADDR_WIDTH:0];
        word_idx   <= '0;
      end
      if (imem_we) begin
        word_idx <= word_idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    imem_we   = 1'b0;
    tx_start  = 1'b0;
    tx_data   = 8'h00;
    unique case (state)
      HDR: begin
        if (bad_byte) begin
          state_nxt = ERR;
        end else if (word_vld_p1) begin
          if (word_p1 == '0)        state_nxt = ACK;
          else if (word_p1 > MAX_N) state_nxt = ERR;
          else                      state_nxt = DATA;
        end
      end
      DATA: begin
        // A completed word is still written even if the next byte is errored
        imem_we = word_vld_p1;
        if (bad_byte)                      state_nxt = ERR;
        else if (word_vld_p1 && last_word) state_nxt = ACK;
      end
      ACK: begin
        if (!tx_busy) begin
          tx_start  = 1'b1;
          tx_data   = ACK_BYTE;
          state_nxt = RUN;
        end
      end
      RUN:     state_nxt = RUN;
      ERR:     state_nxt = ERR;
      default: state_nxt = HDR;
    endcase
  end

  assign imem_addr  = word_idx;
  assign imem_wdata = word_p1;
  assign core_rstn  = (state == RUN);
  assign load_done  = (state == RUN);
  assign load_err   = (state == ERR);

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: table of load scenarios plus a mid-load reset sequence.
module tb_uart_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic        rx_ferr = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rstn;
  logic        load_done;
  logic        load_err;

  int checks = 0;
  int failures = 0;

  logic [9:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          tx_cnt = 0;
  logic [7:0]  tx_last = 8'h00;
  logic        prev_tx = 1'b0;

  uart_loader dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .rx_ferr    (rx_ferr),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rstn  (core_rstn),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Observe outputs on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rstn) begin
      if (imem_we) begin
        wa_q.push_back(imem_addr);
        wd_q.push_back(imem_wdata);
      end
      if (prev_tx) chk("core_rstn_after_ack", {31'd0, core_rstn}, 32'd1);
      if (tx_start) begin
        tx_cnt++;
        tx_last = tx_data;
        chk("core_rstn_during_ack", {31'd0, core_rstn}, 32'd0);
      end
      prev_tx = tx_start;
    end else begin
      prev_tx = 1'b0;
    end
  end

  typedef struct {
    string            name;
    logic [31:0]      n_hdr;
    int               n_send;
    logic [3:0][31:0] words;
    int               ferr_idx;
    int               busy;
    int               exp_writes;
    logic             exp_ack;
    logic             exp_err;
  } scn_t;

  scn_t tbl[5];

  task automatic send_byte(input logic [7:0] b, input logic f);
    @(posedge clk); #1;
    rx_data  = b;
    rx_ready = 1'b1;
    rx_ferr  = f;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    rx_ferr  = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b0);
  endtask

  task automatic do_reset();
    #3;
    rstn     = 1'b0;
    rx_ready = 1'b0;
    rx_ferr  = 1'b0;
    tx_busy  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_core_rstn", {31'd0, core_rstn}, 32'd0);
    chk("rst_load_done", {31'd0, load_done}, 32'd0);
    chk("rst_load_err", {31'd0, load_err}, 32'd0);
    chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
    chk("rst_tx", {23'd0, tx_start, tx_data}, 32'd0);
    chk("rst_imem_bus", {imem_wdata[21:0], imem_addr}, 32'd0);
    wa_q.delete();
    wd_q.delete();
    tx_cnt  = 0;
    tx_last = 8'h00;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic run_scn(input scn_t s);
    int nbytes;
    logic [7:0] b;
    do_reset();
    tx_busy = (s.busy > 0);
    nbytes = 4 + 4 * s.n_send;
    for (int idx = 0; idx < nbytes; idx++) begin
      if (idx < 4) b = s.n_hdr[8*idx +: 8];
      else         b = s.words[(idx-4)/4][8*((idx-4)%4) +: 8];
      send_byte(b, idx == s.ferr_idx);
    end
    if (s.busy > 0) begin
      // A stray byte while waiting for the transmitter must be ignored
      for (int i = 0; i < s.busy; i++) begin
        @(posedge clk); #1;
        rx_data  = 8'h55;
        rx_ready = (i == 50);
      end
      chk({s.name, "_ack_held"}, tx_cnt, 0);
      chk({s.name, "_core_held"}, {31'd0, core_rstn}, 32'd0);
      @(posedge clk); #1;
      rx_ready = 1'b0;
      tx_busy  = 1'b0;
      @(negedge clk);
      chk({s.name, "_ack_after_busy"}, {23'd0, tx_start, tx_data}, {23'd0, 1'b1, 8'hAA});
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk({s.name, "_writes"}, wa_q.size(), s.exp_writes);
    for (int k = 0; k < s.exp_writes && k < wa_q.size(); k++) begin
      chk({s.name, "_addr"}, {22'd0, wa_q[k]}, k);
      chk({s.name, "_data"}, wd_q[k], s.words[k]);
    end
    chk({s.name, "_tx_cnt"}, tx_cnt, s.exp_ack ? 1 : 0);
    if (s.exp_ack) chk({s.name, "_tx_data"}, {24'd0, tx_last}, 32'h0000_00AA);
    chk({s.name, "_core_rstn"}, {31'd0, core_rstn}, {31'd0, s.exp_ack});
    chk({s.name, "_load_done"}, {31'd0, load_done}, {31'd0, s.exp_ack});
    chk({s.name, "_load_err"}, {31'd0, load_err}, {31'd0, s.exp_err});
    // Bytes after completion or error change nothing
    send_word(32'h0000_0001);
    send_word(32'h1234_5678);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({s.name, "_no_extra_writes"}, wa_q.size(), s.exp_writes);
    chk({s.name, "_no_extra_tx"}, tx_cnt, s.exp_ack ? 1 : 0);
    chk({s.name, "_final_flags"}, {29'd0, core_rstn, load_done, load_err},
        {29'd0, s.exp_ack, s.exp_ack, s.exp_err});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{"load3", 32'd3, 3, {32'h0, 32'h00200223, 32'h00100113, 32'h00100093},
               -1, 0, 3, 1'b1, 1'b0};
    tbl[1] = '{"n0", 32'd0, 0, {32'h0, 32'h0, 32'h0, 32'h0}, -1, 0, 0, 1'b1, 1'b0};
    tbl[2] = '{"too_big", 32'h0000_0401, 1, {32'h0, 32'h0, 32'h0, 32'hCAFE_F00D},
               -1, 0, 0, 1'b0, 1'b1};
    tbl[3] = '{"ferr", 32'd2, 2, {32'h0, 32'h0, 32'h8765_4321, 32'h1122_3344},
               9, 0, 1, 1'b0, 1'b1};
    tbl[4] = '{"busy", 32'd1, 1, {32'h0, 32'h0, 32'h0, 32'h0000_0013},
               -1, 100, 1, 1'b1, 1'b0};

    for (int i = 0; i < 5; i++) run_scn(tbl[i]);

    // Reset in the middle of DATA, then a fresh one-word load
    do_reset();
    send_word(32'd2);
    send_word(32'hA5A5_0001);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    chk("midrst_core_rstn", {31'd0, core_rstn}, 32'd0);
    chk("midrst_flags", {30'd0, load_done, load_err}, 32'd0);
    chk("midrst_imem_we", {31'd0, imem_we}, 32'd0);
    chk("midrst_addr", {22'd0, imem_addr}, 32'd0);
    chk("midrst_wdata", imem_wdata, 32'd0);
    chk("midrst_tx", {23'd0, tx_start, tx_data}, 32'd0);
    chk("midrst_prior_write", wa_q.size(), 1);
    @(posedge clk); #1;
    wa_q.delete();
    wd_q.delete();
    tx_cnt = 0;
    rstn   = 1'b1;
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("reload_writes", wa_q.size(), 1);
    if (wa_q.size() > 0) begin
      chk("reload_addr", {22'd0, wa_q[0]}, 32'd0);
      chk("reload_data", wd_q[0], 32'hDEAD_BEEF);
    end
    chk("reload_tx_cnt", tx_cnt, 1);
    chk("reload_core_rstn", {31'd0, core_rstn}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
